// File: rtl/ddram_pkg.sv
// Shared types and line geometry for the multi-channel DDRAM byte reader.
package ddram_pkg;

    localparam int LINE_BYTES = 8;
    localparam int LANE_BITS  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Little-endian lane pick: lane 0 is bits 7:0.
    function automatic logic [7:0] lane_byte(input logic [LINE_BYTES*8-1:0] word,
                                             input logic [LANE_BITS-1:0]    lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search begins at the requester after 'last'.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant,
    output logic                 valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!valid && req[(int'(last) + k) % N]) begin
                grant[(int'(last) + k) % N] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddram_multi_reader.sv
// Per-channel one-line byte caches in front of a single 64-bit DDRAM read port,
// with round-robin miss service and shared fills for channels wanting the same line.
module ddram_multi_reader
    import ddram_pkg::*;
#(
    parameter int NCH = 4,
    parameter int AW  = 28
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [NCH-1:0]    ch_rd,
    input  logic [NCH*AW-1:0] ch_addr,
    output logic [NCH*8-1:0]  ch_dout,
    output logic [NCH-1:0]    ch_ready,
    input  logic              cache_inv,
    output logic              mem_rd,
    output logic [AW-4:0]     mem_addr,
    input  logic              mem_busy,
    input  logic [63:0]       mem_dout,
    input  logic              mem_dout_ready
);

    localparam int TW = AW - LANE_BITS;
    localparam int LW = $clog2(NCH);

    state_e          state_q;
    logic            mem_rd_q;
    logic [TW-1:0]   mem_addr_q;
    logic [LW-1:0]   last_q;
    logic            inv_seen_q;

    logic [NCH-1:0]  pend;
    logic [TW-1:0]   ptag [NCH];
    logic [NCH-1:0]  arb_grant;
    logic            arb_valid;
    logic [LW-1:0]   arb_idx;
    logic            fill_now;

    // Responses are only meaningful while a read is outstanding.
    assign fill_now = (state_q == ST_WAIT) && mem_dout_ready;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [AW-1:0] addr;
        logic [63:0]   line_q;
        logic [TW-1:0] tag_q;
        logic          valid_q;
        logic          pend_q;
        logic          ready_q;
        logic [AW-1:0] paddr_q;
        logic [7:0]    dout_q;
        logic          hit;
        logic          miss;
        logic          fill_hit;

        assign addr     = ch_addr[gi*AW +: AW];
        assign hit      = ch_rd[gi] && !pend_q && !cache_inv && valid_q &&
                          (tag_q == addr[AW-1:LANE_BITS]);
        assign miss     = ch_rd[gi] && !pend_q && !hit;
        assign fill_hit = fill_now && pend_q && (paddr_q[AW-1:LANE_BITS] == mem_addr_q);

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                line_q  <= '0;
                tag_q   <= '0;
                valid_q <= 1'b0;
                pend_q  <= 1'b0;
                ready_q <= 1'b0;
                paddr_q <= '0;
                dout_q  <= '0;
            end else begin
                ready_q <= 1'b0;
                if (cache_inv) begin
                    valid_q <= 1'b0;
                end
                if (hit) begin
                    ready_q <= 1'b1;
                    dout_q  <= lane_byte(line_q, addr[LANE_BITS-1:0]);
                end
                if (miss) begin
                    pend_q  <= 1'b1;
                    paddr_q <= addr;
                end
                // An invalidate seen during this read still delivers the byte but leaves the line invalid.
                if (fill_hit) begin
                    line_q  <= mem_dout;
                    tag_q   <= mem_addr_q;
                    valid_q <= !(inv_seen_q || cache_inv);
                    pend_q  <= 1'b0;
                    ready_q <= 1'b1;
                    dout_q  <= lane_byte(mem_dout, paddr_q[LANE_BITS-1:0]);
                end
            end
        end

        assign pend[gi]            = pend_q;
        assign ptag[gi]            = paddr_q[AW-1:LANE_BITS];
        assign ch_dout[gi*8 +: 8]  = dout_q;
        assign ch_ready[gi]        = ready_q;
    end

    rr_arbiter #(.N(NCH)) u_arb (
        .req   (pend),
        .last  (last_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        arb_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            if (arb_grant[k]) begin
                arb_idx = LW'(k);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            last_q     <= LW'(NCH - 1);
            inv_seen_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                inv_seen_q <= 1'b0;
            end else if (cache_inv) begin
                inv_seen_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        last_q     <= arb_idx;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= ptag[arb_idx];
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!mem_busy) begin
                        mem_rd_q <= 1'b0;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_dout_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: doc/ddram_multi_reader.md
DDRAM_MULTI_READER -- requirements
Module: ddram_multi_reader

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent byte-read channels (2..8).
REQ-002 SHALL have parameter AW, default 28, byte-address width.
REQ-003 SHALL have port clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port ch_rd  in  NCH  per-channel one-cycle read request.
REQ-006 SHALL have port ch_addr  in  NCH*AW  per-channel byte address, sampled with ch_rd.
REQ-007 SHALL have port ch_dout  out  NCH*8  per-channel returned byte, held until the next ch_ready.
REQ-008 SHALL have port ch_ready  out  NCH  per-channel one-cycle data-valid pulse.
REQ-009 SHALL have port cache_inv  in  1  pulse; clears all line-valid bits (used at new wav load).
REQ-010 SHALL have ports mem_rd out 1, mem_addr out AW-3, mem_busy in 1, mem_dout in 64, mem_dout_ready in 1: the 64-bit word read port to the DDRAM bridge, burst of one word.

Function
REQ-011 SHALL keep one 64-bit line buffer per channel with tag = addr[AW-1:3] and a valid bit.
REQ-012 SHALL select byte lane addr[2:0], lane 0 = bits 7:0 (little-endian).
REQ-013 SHALL, on ch_rd hitting a valid matching line, assert ch_ready exactly 1 cycle later with the byte; no memory access.
REQ-014 SHALL, on a miss, set that channel's pending flag and latch the address.
REQ-015 SHALL ignore ch_rd on a channel whose pending flag is set; latched address unchanged.
REQ-016 SHALL arbitrate pending channels round-robin; search starts at the channel after the last granted; after reset, channel 0 has priority.
REQ-017 SHALL run FSM IDLE -> ISSUE (grant taken, mem_rd=1, mem_addr=tag) -> WAIT (mem_rd=0 from first cycle mem_busy=0 in ISSUE) -> IDLE on mem_dout_ready.
REQ-018 SHALL hold mem_rd and mem_addr stable while mem_busy=1 in ISSUE.
REQ-019 SHALL, on mem_dout_ready, load the word into the granted channel's buffer, set valid, clear pending, and pulse ch_ready the next cycle.
REQ-020 SHALL, in the same fill, also complete every other pending channel whose tag equals the fill tag (shared fill), loading their buffers and pulsing their ch_ready in the same cycle.
REQ-021 SHALL ignore mem_dout_ready outside WAIT.
REQ-022 SHALL, on cache_inv, clear all valid bits; a fill completing in the same cycle or later in the same WAIT still delivers bytes to requesters but leaves valid=0.
REQ-023 SHALL, on ch_rd coincident with cache_inv, treat the request as a miss.
REQ-024 SHALL, when ch_rd hits a line being loaded in the same cycle, treat it as a miss (no forwarding).
REQ-025 SHALL allow at most one outstanding memory read.

Reset
REQ-026 SHALL, on reset_n low, immediately clear: FSM=IDLE, mem_rd=0, mem_addr=0, ch_ready=0, ch_dout=0, all pending and valid bits=0, RR pointer=NCH-1.
REQ-027 SHALL discard any in-flight memory response after reset; a mem_dout_ready arriving in IDLE produces no ch_ready.

Structure
REQ-028 SHALL place the FSM state enum and lane-width constants (LINE_BYTES=8, LANE_BITS=3) in shared package ddram_pkg.
REQ-029 SHALL implement the round-robin grant as sub-module rr_arbiter (parameter N; inputs req, last; outputs grant one-hot, valid).

Verification
REQ-030 SHALL cover: NCH=4, ch0 reads 0x100..0x107 sequentially -> one mem_rd with mem_addr=0x20, then seven hits each with ch_ready 1 cycle after ch_rd, bytes match lanes 0..7.
REQ-031 SHALL cover: ch0 and ch2 miss same cycle, addrs 0x40 and 0x8000 -> ch0 granted first, then ch2; next round with both pending grants ch3/ch0 order per pointer.
REQ-032 SHALL cover: ch1 and ch3 miss addrs 0x208 and 0x20F -> single mem_rd at 0x41, both ch_ready pulses same cycle with correct lanes.
REQ-033 SHALL cover: mem_busy held 5 cycles in ISSUE -> mem_rd/mem_addr stable all 5 cycles, exactly one accepted request.
REQ-034 SHALL cover: cache_inv during WAIT -> requester gets byte; immediate re-read of same address causes a new mem_rd.
REQ-035 SHALL cover: reset_n low in WAIT, then stray mem_dout_ready -> all outputs zero, no ch_ready, FSM IDLE.
